// File: rtl/decode_queue_if.sv
// Handshake and decoded-entry bus between fetch, the decode queue and the issue side.
// The slave modport is the queue's view. The master modport is the surrounding fetch/issue logic.
interface decode_queue_if;
  logic        in_valid;
  logic [31:0] in_ins;
  logic [31:0] in_pc;
  logic        in_jp_flag;
  logic [31:0] in_jp_pc;
  logic        in_ready;

  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [5:0]  out_insty;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic [31:0] out_jp_pc;
  logic        out_jp_flag;
  logic        out_to_lsb;
  logic        out_to_rs;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_ins, in_pc, in_jp_flag, in_jp_pc, out_ready,
    output in_ready, out_valid, out_rd, out_rs1, out_rs2, out_insty, out_imm,
           out_pc, out_jp_pc, out_jp_flag, out_to_lsb, out_to_rs, out_illegal
  );

  modport master (
    output in_valid, in_ins, in_pc, in_jp_flag, in_jp_pc, out_ready,
    input  in_ready, out_valid, out_rd, out_rs1, out_rs2, out_insty, out_imm,
           out_pc, out_jp_pc, out_jp_flag, out_to_lsb, out_to_rs, out_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode stage followed by a FIFO of decoded entries; flush empties it in one cycle.
// Optional macro DECODE_ILLEGAL_EN flags unknown opcodes and undefined load/store/branch funct3.
module decode_queue #(
  parameter int QUEUE_DEPTH = 4,
  parameter int PTR_W       = $clog2(QUEUE_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           flush,
  decode_queue_if.slave  q,
  output logic [PTR_W:0] count
);

  localparam logic [5:0] LB    = 6'd1,  LH    = 6'd2,  LW    = 6'd3,  LBU   = 6'd4;
  localparam logic [5:0] LHU   = 6'd5,  SB    = 6'd6,  SH    = 6'd7,  SW    = 6'd8;
  localparam logic [5:0] ADD   = 6'd9,  SUB   = 6'd10, SLL   = 6'd11, SLT   = 6'd12;
  localparam logic [5:0] SLTU  = 6'd13, XOR_  = 6'd14, SRL   = 6'd15, SRA   = 6'd16;
  localparam logic [5:0] OR_   = 6'd17, AND_  = 6'd18, ADDI  = 6'd19, SLTI  = 6'd20;
  localparam logic [5:0] SLTIU = 6'd21, XORI  = 6'd22, ORI   = 6'd23, ANDI  = 6'd24;
  localparam logic [5:0] SLLI  = 6'd25, SRLI  = 6'd26, SRAI  = 6'd27, BEQ   = 6'd28;
  localparam logic [5:0] BNE   = 6'd29, BLT   = 6'd30, BGE   = 6'd31, BLTU  = 6'd32;
  localparam logic [5:0] BGEU  = 6'd33, LUI   = 6'd34, AUIPC = 6'd35, JAL   = 6'd36;
  localparam logic [5:0] JALR  = 6'd37;

  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_OPIMM  = 7'd19;
  localparam logic [6:0] OPC_OP     = 7'd51;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_LUI    = 7'd55;
  localparam logic [6:0] OPC_AUIPC  = 7'd23;
  localparam logic [6:0] OPC_JAL    = 7'd111;
  localparam logic [6:0] OPC_JALR   = 7'd103;

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [5:0]  insty;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] jp_pc;
    logic        jp_flag;
    logic        to_lsb;
    logic        to_rs;
    logic        illegal;
  } entry_t;

  entry_t           mem [QUEUE_DEPTH];
  entry_t           dec;
  entry_t           head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             enq;
  logic             deq;
  logic             known;

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_sh, imm_s, imm_b, imm_u, imm_j;

  assign ins    = q.in_ins;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_sh = {27'd0, ins[24:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'd0};
  assign imm_j  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

  // Decode the offered instruction; unknown encodings fall back to insty = 0 and imm = 0.
  always_comb begin
    dec         = '0;
    known       = 1'b1;
    dec.pc      = q.in_pc;
    dec.jp_pc   = q.in_jp_pc;
    dec.jp_flag = q.in_jp_flag;
    dec.rd      = (opcode == OPC_BRANCH || opcode == OPC_STORE) ? 5'd0 : ins[11:7];
    dec.rs1     = (opcode == OPC_JAL || opcode == OPC_LUI || opcode == OPC_AUIPC)
                  ? 5'd0 : ins[19:15];
    dec.rs2     = (opcode == OPC_BRANCH || opcode == OPC_STORE || opcode == OPC_OP)
                  ? ins[24:20] : 5'd0;
    case (opcode)
      OPC_LOAD: begin
        dec.imm = imm_i;
        case (funct3)
          3'd0:    dec.insty = LB;
          3'd1:    dec.insty = LH;
          3'd2:    dec.insty = LW;
          3'd4:    dec.insty = LBU;
          3'd5:    dec.insty = LHU;
          default: known = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec.imm = imm_s;
        case (funct3)
          3'd0:    dec.insty = SB;
          3'd1:    dec.insty = SH;
          3'd2:    dec.insty = SW;
          default: known = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        dec.imm = imm_i;
        case (funct3)
          3'd0: dec.insty = ADDI;
          3'd2: dec.insty = SLTI;
          3'd3: dec.insty = SLTIU;
          3'd4: dec.insty = XORI;
          3'd6: dec.insty = ORI;
          3'd7: dec.insty = ANDI;
          3'd1: begin
            dec.insty = SLLI;
            dec.imm   = imm_sh;
          end
          default: begin
            dec.insty = ins[30] ? SRAI : SRLI;
            dec.imm   = imm_sh;
          end
        endcase
      end
      OPC_OP: begin
        case (funct3)
          3'd0:    dec.insty = ins[30] ? SUB : ADD;
          3'd1:    dec.insty = SLL;
          3'd2:    dec.insty = SLT;
          3'd3:    dec.insty = SLTU;
          3'd4:    dec.insty = XOR_;
          3'd5:    dec.insty = ins[30] ? SRA : SRL;
          3'd6:    dec.insty = OR_;
          default: dec.insty = AND_;
        endcase
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        case (funct3)
          3'd0:    dec.insty = BEQ;
          3'd1:    dec.insty = BNE;
          3'd4:    dec.insty = BLT;
          3'd5:    dec.insty = BGE;
          3'd6:    dec.insty = BLTU;
          3'd7:    dec.insty = BGEU;
          default: known = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.insty = LUI;
        dec.imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec.insty = AUIPC;
        dec.imm   = imm_u;
      end
      OPC_JAL: begin
        dec.insty = JAL;
        dec.imm   = imm_j;
      end
      OPC_JALR: begin
        dec.insty = JALR;
        dec.imm   = imm_i;
      end
      default: known = 1'b0;
    endcase
    if (known) begin
      dec.to_lsb = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
      dec.to_rs  = (opcode == OPC_OPIMM) || (opcode == OPC_OP) ||
                   (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
    end else begin
      dec.insty = 6'd0;
      dec.imm   = 32'd0;
    end
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = !known;
`else
    dec.illegal = 1'b0;
`endif
  end

  // Handshake readiness comes only from the occupancy register, never from the peer's valid/ready.
  assign q.in_ready  = (count != CNT_FULL);
  assign q.out_valid = (count != '0);

  assign enq = q.in_valid && q.in_ready && rdy && !flush && !rst;
  assign deq = q.out_valid && q.out_ready && rdy && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (enq) tail <= tail + PTR_ONE;
      if (deq) head <= head + PTR_ONE;
      if (enq && !deq)      count <= count + CNT_ONE;
      else if (deq && !enq) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= dec;
  end

  assign head_entry    = q.out_valid ? mem[head] : '0;
  assign q.out_rd      = head_entry.rd;
  assign q.out_rs1     = head_entry.rs1;
  assign q.out_rs2     = head_entry.rs2;
  assign q.out_insty   = head_entry.insty;
  assign q.out_imm     = head_entry.imm;
  assign q.out_pc      = head_entry.pc;
  assign q.out_jp_pc   = head_entry.jp_pc;
  assign q.out_jp_flag = head_entry.jp_flag;
  assign q.out_to_lsb  = head_entry.to_lsb;
  assign q.out_to_rs   = head_entry.to_rs;
  assign q.out_illegal = head_entry.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue: decode table, fill/drain, overlap, flush, illegal.
module tb_decode_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdy = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] count;
  int         checks = 0;
  int         errors = 0;

  decode_queue_if dq_if ();

  decode_queue #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .q     (dq_if),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [5:0]  insty;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        to_lsb, to_rs;
  } vec_t;

  vec_t vecs [7];

`ifdef DECODE_ILLEGAL_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One clock with the given offer/consume; both strobes drop afterwards, sampling happens 1ns past the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic o_r);
    dq_if.in_valid   = v;
    dq_if.in_ins     = ins;
    dq_if.in_pc      = pc;
    dq_if.in_jp_pc   = pc + 32'h100;
    dq_if.in_jp_flag = pc[2];
    dq_if.out_ready  = o_r;
    @(posedge clk);
    #1;
    dq_if.in_valid  = 1'b0;
    dq_if.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] addi_rd(input logic [4:0] r);
    return {7'd0, r, 5'd0, 3'd0, r, 7'd19};
  endfunction

  initial begin
    vecs[0] = '{32'h00500093, 6'd19, 5'd1, 5'd0, 5'd0, 32'd5,        1'b0, 1'b1};
    vecs[1] = '{32'hFE20AE23, 6'd8,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 1'b0};
    vecs[2] = '{32'h00208463, 6'd28, 5'd0, 5'd1, 5'd2, 32'd8,        1'b0, 1'b1};
    vecs[3] = '{32'h123452B7, 6'd34, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0};
    vecs[4] = '{32'hFFDFF0EF, 6'd36, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[5] = '{32'h40725193, 6'd27, 5'd3, 5'd4, 5'd0, 32'd7,        1'b0, 1'b1};
    vecs[6] = '{32'h407302B3, 6'd10, 5'd5, 5'd6, 5'd7, 32'd0,        1'b0, 1'b1};

    dq_if.in_valid   = 1'b0;
    dq_if.in_ins     = '0;
    dq_if.in_pc      = '0;
    dq_if.in_jp_pc   = '0;
    dq_if.in_jp_flag = 1'b0;
    dq_if.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_in_ready", 32'(dq_if.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(dq_if.out_valid), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_insty", 32'(dq_if.out_insty), 32'd0);
    checkOutput("reset_imm", dq_if.out_imm, 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vecs[i].ins, 32'(i * 4), 1'b0);
      checkOutput($sformatf("dec%0d_valid", i), 32'(dq_if.out_valid), 32'd1);
      checkOutput($sformatf("dec%0d_insty", i), 32'(dq_if.out_insty), 32'(vecs[i].insty));
      checkOutput($sformatf("dec%0d_rd", i), 32'(dq_if.out_rd), 32'(vecs[i].rd));
      checkOutput($sformatf("dec%0d_rs1", i), 32'(dq_if.out_rs1), 32'(vecs[i].rs1));
      checkOutput($sformatf("dec%0d_rs2", i), 32'(dq_if.out_rs2), 32'(vecs[i].rs2));
      checkOutput($sformatf("dec%0d_imm", i), dq_if.out_imm, vecs[i].imm);
      checkOutput($sformatf("dec%0d_lsb", i), 32'(dq_if.out_to_lsb), 32'(vecs[i].to_lsb));
      checkOutput($sformatf("dec%0d_rs", i), 32'(dq_if.out_to_rs), 32'(vecs[i].to_rs));
      checkOutput($sformatf("dec%0d_pc", i), dq_if.out_pc, 32'(i * 4));
      checkOutput($sformatf("dec%0d_jppc", i), dq_if.out_jp_pc, 32'(i * 4) + 32'h100);
      checkOutput($sformatf("dec%0d_illegal", i), 32'(dq_if.out_illegal), 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      checkOutput($sformatf("dec%0d_drained", i), 32'(dq_if.out_valid), 32'd0);
      checkOutput($sformatf("dec%0d_empty_rd", i), 32'(dq_if.out_rd), 32'd0);
    end

    // Offer DEPTH+1 with the consumer stalled; only DEPTH get in.
    for (int i = 1; i <= DEPTH + 1; i++) begin
      applyStimulus(1'b1, addi_rd(5'(i)), 32'(i * 4), 1'b0);
      checkOutput($sformatf("fill%0d_count", i), 32'(count), (i > DEPTH) ? 32'(DEPTH) : 32'(i));
      checkOutput($sformatf("fill%0d_in_ready", i), 32'(dq_if.in_ready), (i >= DEPTH) ? 32'd0 : 32'd1);
    end
    rdy = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    rdy = 1'b1;
    checkOutput("hold_count", 32'(count), 32'(DEPTH));
    checkOutput("hold_head_rd", 32'(dq_if.out_rd), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      checkOutput($sformatf("drain%0d_rd", i), 32'(dq_if.out_rd), 32'(i));
      checkOutput($sformatf("drain%0d_imm", i), dq_if.out_imm, 32'(i));
      checkOutput($sformatf("drain%0d_pc", i), dq_if.out_pc, 32'(i * 4));
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    end
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_out_valid", 32'(dq_if.out_valid), 32'd0);

    applyStimulus(1'b1, addi_rd(5'd1), 32'h40, 1'b0);
    applyStimulus(1'b1, addi_rd(5'd2), 32'h44, 1'b0);
    applyStimulus(1'b1, addi_rd(5'd3), 32'h48, 1'b1);
    checkOutput("overlap_count", 32'(count), 32'd2);
    checkOutput("overlap_head_rd", 32'(dq_if.out_rd), 32'd2);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    checkOutput("overlap_tail_rd", 32'(dq_if.out_rd), 32'd3);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    checkOutput("overlap_empty", 32'(count), 32'd0);

    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, addi_rd(5'(i)), 32'(i * 4), 1'b0);
    checkOutput("preflush_count", 32'(count), 32'd3);
    flush = 1'b1;
    applyStimulus(1'b1, addi_rd(5'd9), 32'h90, 1'b1);
    flush = 1'b0;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_out_valid", 32'(dq_if.out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(dq_if.in_ready), 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("flush_not_enqueued", 32'(count), 32'd0);

    applyStimulus(1'b1, addi_rd(5'd4), 32'h10, 1'b0);
    rdy = 1'b0;
    flush = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    flush = 1'b0;
    rdy = 1'b1;
    checkOutput("flush_nordy_count", 32'(count), 32'd0);

    applyStimulus(1'b1, 32'h0000007F, 32'h200, 1'b0);
    checkOutput("ill_op_valid", 32'(dq_if.out_valid), 32'd1);
    checkOutput("ill_op_flag", 32'(dq_if.out_illegal), 32'(ILL_EXP));
    checkOutput("ill_op_insty", 32'(dq_if.out_insty), 32'd0);
    checkOutput("ill_op_imm", dq_if.out_imm, 32'd0);
    checkOutput("ill_op_rs", 32'(dq_if.out_to_rs), 32'd0);
    applyStimulus(1'b1, 32'h0000B003, 32'h204, 1'b1);
    checkOutput("ill_ld_head", 32'(dq_if.out_pc), 32'h204);
    checkOutput("ill_ld_flag", 32'(dq_if.out_illegal), 32'(ILL_EXP));
    checkOutput("ill_ld_insty", 32'(dq_if.out_insty), 32'd0);
    checkOutput("ill_ld_lsb", 32'(dq_if.out_to_lsb), 32'd0);
    checkOutput("ill_ld_rs1", 32'(dq_if.out_rs1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered RV32I decode stage between InstFetch and the issue side (ROB/LSB/RS). Each fetched instruction is decoded as it is accepted and stored in a parametrised FIFO of decoded entries. The FIFO decouples fetch from issue back-pressure with a valid/ready handshake, so a full ROB or LSB no longer drops or re-fetches instructions. A mispredict flush empties the queue in one cycle.

## Interface
- QUEUE_DEPTH, 4, number of decoded entries; power of two, ≥2
- PTR_W, $clog2(QUEUE_DEPTH), head/tail pointer width
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  jump-wrong flush
- in_valid  in  1  fetch offers an instruction
- in_ins  in  32  raw instruction
- in_pc  in  32  instruction PC
- in_jp_flag  in  1  predicted-taken flag
- in_jp_pc  in  32  predicted target
- in_ready  out  1  queue can accept (count < QUEUE_DEPTH)
- out_valid  out  1  head entry valid
- out_ready  in  1  issue side consumes head (driven as !ROB_full && !LSB_full)
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 where unused
- out_insty  out  6  instruction type code per the team's defines (`LB … `JALR)
- out_imm  out  32  decoded immediate
- out_pc, out_jp_pc  out  32 each  carried PC and predicted target
- out_jp_flag  out  1  carried prediction flag
- out_to_lsb  out  1  opcode is load (3) or store (35)
- out_to_rs  out  1  opcode is OP-IMM (19), OP (51), BRANCH (99) or JALR (103)
- out_illegal  out  1  unrecognised opcode/funct3 (see Configuration)
- count  out  PTR_W+1  current occupancy (debug/verification)

## Operation
- Enqueue when in_valid && in_ready && rdy && !flush: decode in_ins and write the decoded entry to tail; tail wraps modulo QUEUE_DEPTH.
- Decode rules:
  - rd = 0 for opcodes 99 and 35.
  - rs1 = 0 for opcodes 111, 55 and 23.
  - rs2 = ins[24:20] only for opcodes 99, 35 and 51; else 0.
  - insty per opcode/funct3/ins[30] as in the RV32I base set.
  - imm per format:
    - I: sign-extended ins[31:20].
    - Shift-immediate: zero-extended ins[24:20].
    - S: {ins[31:25], ins[11:7]} sign-extended.
    - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0} sign-extended.
    - U: {ins[31:12], 12'b0}.
    - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0} sign-extended.
    - R-type: 0.
- Dequeue when out_valid && out_ready && rdy && !flush: head advances with wrap.
- Outputs are driven combinationally from the head entry. When the queue is empty, all output fields are 0 and out_valid = 0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. When full, in_ready = 0 even if a dequeue occurs in the same cycle (no same-cycle pass-through).
- flush (regardless of rdy): head = tail = 0, count = 0, and any offered enqueue or dequeue that cycle is discarded.
- rst: identical to flush. Entry storage contents are don't-care.

## Timing
- Reset values: in_ready = 1, out_valid = 0, count = 0, all output fields 0.
- Latency: an instruction accepted at edge N is visible at the head (if the queue was empty) after edge N, so out_valid = 1 in cycle N+1.
- Throughput: one enqueue and one dequeue per cycle.
- rdy = 0: pointers, count and entries hold. Outputs continue to reflect the head entry.
- in_ready and out_valid depend only on count, with no combinational path from out_ready or in_valid.

## Configuration
- DECODE_ILLEGAL_EN defined:
  - Opcodes outside {3, 35, 19, 51, 99, 55, 23, 111, 103} set out_illegal = 1.
  - Undefined funct3 values for load, store and branch also set out_illegal = 1.
  - Such entries have insty = 0, out_to_lsb = 0 and out_to_rs = 0, and are still queued in order.
- Undefined: out_illegal is tied to 0. Unknown encodings are queued with insty = 0 and imm = 0, and all flags are 0.

## Test plan
- After reset, enqueue 0x00500093 (addi x1, x0, 5) at pc 0x0 -> next cycle out_valid = 1, insty = `ADDI, rd = 1, rs1 = 0, rs2 = 0, imm = 5, out_to_rs = 1.
- Enqueue 0xFE20AE23 (sw x2, -4(x1)) -> insty = `SW, rd = 0, rs1 = 1, rs2 = 2, imm = 0xFFFFFFFC, out_to_lsb = 1, out_to_rs = 0.
- Hold out_ready = 0 and enqueue QUEUE_DEPTH + 1 instructions -> in_ready falls after QUEUE_DEPTH accepts and count = QUEUE_DEPTH. Release out_ready -> entries drain in order and pointers wrap correctly.
- With count = 2, assert in_valid and out_ready in the same cycle -> count stays 2 and the head advances to the second entry.
- With 3 entries queued, assert flush together with in_valid -> next cycle count = 0, out_valid = 0, and the offered instruction is not enqueued.
- With DECODE_ILLEGAL_EN defined, enqueue 0x0000007F -> out_illegal = 1 and insty = 0. Without the macro -> out_illegal = 0.
